// File: rtl/sbox_arb_pkg.sv
// ----------------------------------------------------------------------------
// sbox_arb_pkg
// Shared definitions for the time-multiplexed AES SubWord engine:
//   - state_t   : controller states (IDLE / RUN / DONE)
//   - WORD_W, BYTE_W, PERF_W : datapath and counter widths
//   - rr_next() : round-robin pointer advance (granted index becomes lowest
//                 priority on the next arbitration)
// No ports (package).
// ----------------------------------------------------------------------------
package sbox_arb_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int PERF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pointer value that makes the just-granted requester lowest priority.
    function automatic int rr_next(input int granted, input int nreq);
        return (granted + 1) % nreq;
    endfunction

endpackage

// File: rtl/sbox.sv
// ----------------------------------------------------------------------------
// sbox
// Combinational AES S-box, forward and inverse, built from the GF(2^8)
// multiplicative inverse plus the (inverse) affine transform rather than a
// lookup table.
// Ports:
//   data_i [7:0] : input byte
//   inv_i        : 1 = inverse S-box, 0 = forward S-box
//   data_o [7:0] : substituted byte
// ----------------------------------------------------------------------------
module sbox (
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    logic [7:0] fwd_s;
    logic [7:0] inv_pre_s;
    logic [7:0] inv_s;

    // Forward path: inverse then affine; inverse path: inverse affine then inverse.
    always_comb begin
        fwd_s     = gf_inv(data_i);
        fwd_s     = fwd_s ^ rotl(fwd_s, 1) ^ rotl(fwd_s, 2) ^ rotl(fwd_s, 3)
                  ^ rotl(fwd_s, 4) ^ 8'h63;
        inv_pre_s = rotl(data_i, 1) ^ rotl(data_i, 3) ^ rotl(data_i, 6) ^ 8'h05;
        inv_s     = gf_inv(inv_pre_s);
        if (inv_i) begin
            data_o = inv_s;
        end else begin
            data_o = fwd_s;
        end
    end

endmodule

// File: rtl/sbox_subword_arb_rr_arb.sv
// ----------------------------------------------------------------------------
// rr_arb
// NREQ-way combinational round-robin arbiter. Searches valid_i starting at
// ptr_i and wrapping, and grants the first set bit.
// Ports:
//   valid_i [NREQ-1:0]  : request vector
//   ptr_i   [IDX_W-1:0] : highest-priority index this cycle
//   grant_o [NREQ-1:0]  : one-hot grant (zero when nothing valid)
//   gidx_o  [IDX_W-1:0] : binary index of the grant (0 when nothing valid)
// ----------------------------------------------------------------------------
module rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] gidx_o
);

    logic found_s;
    int   idx_s;

    // Rotating priority search from ptr_i upward.
    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = (int'(ptr_i) + i) % NREQ;
            if (!found_s && valid_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                gidx_o         = IDX_W'(idx_s);
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sbox_subword_arb.sv
// ----------------------------------------------------------------------------
// sbox_subword_arb
// Shares one byte-wide AES S-box among NREQ requesters. A granted 32-bit
// SubWord / InvSubWord request is rotated through the S-box one byte per
// cycle (4 cycles), then returned on a valid/ready response channel.
// Optional build macro: SBOX_ARB_PERF_EN adds per-requester saturating
// grant counters (perf_clr input, perf_grants output).
// Ports:
//   g_clk, g_reset        : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake
//   req_word [NREQ*32]    : request words, requester i at [32*i+:32]
//   req_inv  [NREQ]       : 1 = inverse S-box
//   rsp_valid/rsp_ready   : per-requester response handshake (owner only)
//   rsp_word [32]         : shared result bus
//   perf_clr, perf_grants : (SBOX_ARB_PERF_EN only) counter clear / counts
// ----------------------------------------------------------------------------
module sbox_subword_arb
    import sbox_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_word,
    input  logic [NREQ-1:0]        req_inv,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [WORD_W-1:0]      rsp_word
`ifdef SBOX_ARB_PERF_EN
    ,
    input  logic                   perf_clr,
    output logic [NREQ*PERF_W-1:0] perf_grants
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [WORD_W-1:0] word_q;
    logic              inv_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [NREQ-1:0]   rsp_valid_q;

    logic [NREQ-1:0]   grant_s;
    logic [IDX_W-1:0]  gidx_s;
    logic              accept_s;
    logic [BYTE_W-1:0] sbox_out_s;
    logic [WORD_W-1:0] word_d;

    rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .gidx_o  (gidx_s)
    );

    sbox u_sbox (
        .data_i (word_q[BYTE_W-1:0]),
        .inv_i  (inv_q),
        .data_o (sbox_out_s)
    );

    // Rotate right by a byte, inserting the substituted byte at the top; after
    // four rotations every byte is back in its original lane.
    assign word_d = {sbox_out_s, word_q[WORD_W-1:BYTE_W]};

    // Grant is only visible while idle; this is the sole combinational path.
    always_comb begin
        if (state_q == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s  = (state_q == IDLE) && (|(req_valid & grant_s));
    assign rsp_valid = rsp_valid_q;
    assign rsp_word  = word_q;

    // Controller FSM with registered response outputs.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            word_q      <= '0;
            inv_q       <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        word_q  <= req_word[WORD_W*int'(gidx_s) +: WORD_W];
                        inv_q   <= req_inv[gidx_s];
                        owner_q <= gidx_s;
                        ptr_q   <= IDX_W'(rr_next(int'(gidx_s), NREQ));
                        cnt_q   <= 2'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    word_q <= word_d;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q     <= DONE;
                        rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                    end
                end
                DONE: begin
                    if (rsp_ready[owner_q]) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= '0;
                end
            endcase
        end
    end

`ifdef SBOX_ARB_PERF_EN
    logic [PERF_W-1:0] perf_q [NREQ];

    // Saturating per-requester accept counters; clear wins over increment.
    always_ff @(posedge g_clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (g_reset || perf_clr) begin
                perf_q[i] <= '0;
            end else if (accept_s && (gidx_s == IDX_W'(i)) && (perf_q[i] != 16'hFFFF)) begin
                perf_q[i] <= perf_q[i] + 16'd1;
            end
        end
    end

    // Flatten counters onto the output bus, requester i at [16*i+:16].
    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            perf_grants[PERF_W*i +: PERF_W] = perf_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_sbox_subword_arb.sv
// ----------------------------------------------------------------------------
// tb_sbox_subword_arb
// Directed self-checking bench for sbox_subword_arb with NREQ = 2. Inputs
// are driven on the falling edge and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sbox_subword_arb;

    logic        g_clk;
    logic        g_reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_word;
    logic [1:0]  req_inv;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_word;
`ifdef SBOX_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_grants;
`endif

    int n_cmp;
    int n_err;

    sbox_subword_arb #(.NREQ(2)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_word  (req_word),
        .req_inv   (req_inv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_word  (rsp_word)
`ifdef SBOX_ARB_PERF_EN
        ,
        .perf_clr    (perf_clr),
        .perf_grants (perf_grants)
`endif
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated transaction for a single requester; response taken immediately.
    task automatic do_txn(input int g, input logic [31:0] w, input logic inv,
                          input logic [31:0] exp);
        logic [1:0] oh;
        oh = 2'b01 << g;
        req_word[32*g +: 32] = w;
        req_inv[g]           = inv;
        req_valid            = oh;
        #1 check_val("txn_ready", {30'd0, req_ready}, {30'd0, oh});
        @(negedge g_clk);
        req_valid = 2'b00;
        repeat (4) @(negedge g_clk);
        check_val("txn_rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        check_val("txn_rsp_word", rsp_word, exp);
        rsp_ready = oh;
        @(negedge g_clk);
        rsp_ready = 2'b00;
        check_val("txn_rsp_drop", {30'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        g_reset   = 1'b1;
        req_valid = 2'b00;
        req_word  = 64'd0;
        req_inv   = 2'b00;
        rsp_ready = 2'b00;
`ifdef SBOX_ARB_PERF_EN
        perf_clr  = 1'b0;
`endif

        // ---------------- reset state ----------------
        do_reset();
        check_val("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_word", rsp_word, 32'd0);
        check_val("rst_req_ready", {30'd0, req_ready}, 32'd0);

        // ------- inverse on req 1 with back-pressure; req 0 waiting -------
        req_word  = {32'h637c777b, 32'h00010203};
        req_inv   = 2'b10;
        req_valid = 2'b10;
        #1 check_val("inv_ready", {30'd0, req_ready}, 32'd2);
        @(negedge g_clk);                         // accepted at E0
        req_valid = 2'b01;                        // req 0 now asks, must stall
        req_word[63:32] = 32'hdeadbeef;           // changes after accept are ignored
        req_inv[1]      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            check_val("inv_run_rspv", {30'd0, rsp_valid}, 32'd0);
            check_val("inv_run_ready", {30'd0, req_ready}, 32'd0);
        end
        @(negedge g_clk);                         // after E4
        check_val("inv_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        check_val("inv_rsp_word", rsp_word, 32'h00010203);
        for (int k = 0; k < 3; k++) begin
            rsp_ready = (k == 1) ? 2'b01 : 2'b00; // non-owner ready is ignored
            @(negedge g_clk);
            check_val("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            check_val("bp_rsp_word", rsp_word, 32'h00010203);
            check_val("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b10;
        @(negedge g_clk);                         // handshake
        rsp_ready = 2'b00;
        check_val("inv_rsp_drop", {30'd0, rsp_valid}, 32'd0);
        check_val("fwd_ready", {30'd0, req_ready}, 32'd1);

        // ------- forward on req 0, exact 4-cycle latency -------
        @(negedge g_clk);                         // accepted at E0
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            check_val("fwd_lat_rspv", {30'd0, rsp_valid}, 32'd0);
        end
        @(negedge g_clk);
        check_val("fwd_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        check_val("fwd_rsp_word", rsp_word, 32'h637c777b);
        rsp_ready = 2'b01;
        @(negedge g_clk);
        rsp_ready = 2'b00;
        check_val("fwd_rsp_drop", {30'd0, rsp_valid}, 32'd0);

        // ------- contention after reset: grants alternate 0,1,0,1 -------
        do_reset();
        req_word  = {32'hffffffff, 32'h00000000};
        req_inv   = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1 check_val("cont_ready", {30'd0, req_ready}, (n % 2 == 0) ? 32'd1 : 32'd2);
            repeat (5) @(negedge g_clk);
            check_val("cont_rsp_valid", {30'd0, rsp_valid}, (n % 2 == 0) ? 32'd1 : 32'd2);
            check_val("cont_rsp_word", rsp_word,
                      (n % 2 == 0) ? 32'h63636363 : 32'h16161616);
            @(negedge g_clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // ------- reset mid-RUN drops the transaction and the pointer -------
        req_word  = {32'h00000000, 32'h00010203};
        req_valid = 2'b01;
        @(negedge g_clk);                         // req 0 accepted, ptr -> 1
        req_valid = 2'b00;
        repeat (2) @(negedge g_clk);              // cnt == 2
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        check_val("mid_rst_word", rsp_word, 32'd0);
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge g_clk);
            check_val("mid_rst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        rsp_ready = 2'b00;
        req_word  = {32'h00000000, 32'hffffffff};
        req_valid = 2'b11;
        #1 check_val("post_rst_grant", {30'd0, req_ready}, 32'd1);
        @(negedge g_clk);
        req_valid = 2'b00;
        repeat (4) @(negedge g_clk);
        check_val("post_rst_rspv", {30'd0, rsp_valid}, 32'd1);
        check_val("post_rst_word", rsp_word, 32'h16161616);
        rsp_ready = 2'b01;
        @(negedge g_clk);
        rsp_ready = 2'b00;

`ifdef SBOX_ARB_PERF_EN
        // ------- grant counters -------
        do_reset();
        check_val("perf_rst", perf_grants, 32'd0);
        do_txn(0, 32'h00010203, 1'b0, 32'h637c777b);
        do_txn(1, 32'h637c777b, 1'b1, 32'h00010203);
        do_txn(0, 32'h00000000, 1'b0, 32'h63636363);
        do_txn(0, 32'hffffffff, 1'b0, 32'h16161616);
        check_val("perf_counts", perf_grants, {16'd1, 16'd3});
        perf_clr = 1'b1;
        @(negedge g_clk);
        perf_clr = 1'b0;
        check_val("perf_clr", perf_grants, 32'd0);
`else
        // ------- a couple of extra isolated transactions -------
        do_txn(1, 32'h63636363, 1'b1, 32'h00000000);
        do_txn(0, 32'h16161616, 1'b1, 32'hffffffff);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule
